pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Carries a {pc, inst} payload between adjacent core stages (IF->ID, ID->EX, and so on) using a valid/ready handshake.
- Includes a 2-entry skid buffer, so the upstream ready is a registered signal with no combinational path from out_ready.
- Adds flush (bubble/NOP injection), an explicit stall, and a saturating stall-cycle counter for performance analysis.

Parameters:
- PC_W, 32, width of the pc payload.
- INST_W, 32, width of the inst payload.
- NOP_INST, 32'h0000_0013, instruction presented on out_inst whenever out_valid=0 (addi x0,x0,0).
- CNT_W, 16, width of the stall_cnt performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  upstream pc.
- in_inst  in  INST_W  upstream instruction.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  pc to next stage.
- out_inst  out  INST_W  instruction to next stage; NOP_INST when out_valid=0.
- flush  in  1  discard all held payloads (branch/trap redirect).
- stall  in  1  hazard hold; treated as out_ready=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and the effective ready low.

Behaviour:
- Reset (async, rst=1):
  - main_v=0, skid_v=0, in_ready=1.
  - out_pc=0, out_inst=NOP_INST, stall_cnt=0.
  - Payload registers cleared to 0.
- Internal signals:
  - eff_ready = out_ready & ~stall.
  - Accept event: in_valid & in_ready.
  - Drain event: main_v & eff_ready.
- Storage: main register (drives the outputs) and skid register. Occupancy states: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1). skid_v=1 implies main_v=1.
- State transitions at the clock edge, when flush=0:
  - EMPTY + accept -> ONE; main <= input. Latency is 1 cycle from accept to out_valid.
  - ONE + accept + drain -> ONE; main <= input (full throughput).
  - ONE + accept + no drain -> FULL; skid <= input.
  - ONE + drain + no accept -> EMPTY.
  - FULL + drain -> ONE; main <= skid. The input is not accepted because in_ready=0.
  - FULL + no drain -> FULL; both registers hold.
- in_ready is a register: in_ready <= ~(next state == FULL). It is therefore 0 exactly while FULL.
- Flush (synchronous):
  - Next state is EMPTY and in_ready <= 1.
  - A payload offered in the same cycle is dropped, even if the accept handshake fired.
  - Flush has priority over stall, accept and drain.
  - Payload registers are not cleared. out_inst shows NOP_INST because out_valid=0.
- Outputs:
  - out_valid = main_v.
  - out_pc = main_v ? main_pc : 0.
  - out_inst = main_v ? main_inst : NOP_INST.
- The payload must stay stable while out_valid=1 and eff_ready=0.
- stall_cnt increments when main_v & ~eff_ready & ~flush, and saturates at all-ones with no wrap. It is cleared only by rst.
- Ordering: payloads leave in acceptance order. No payload is duplicated or lost except by flush.
- Reset asserted mid-transfer: the state returns to EMPTY immediately and asynchronously. Nothing is output after reset deasserts until a new accept.

Decomposition:
- core_pkg holds:
  - XLEN = 32.
  - NOP_INST = 32'h0000_0013.
  - A pipe_payload_t struct {pc, inst}, used as the default type of the stage payload.
- One natural sub-module: pipe_skid_buf, a generic width-parametrised 2-entry valid/ready skid buffer with flush.
  - pipe_stage_skid wraps it and adds the NOP/pc output masking, stall gating and stall_cnt.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release -> in_ready=1, out_valid=0, out_inst=32'h13, out_pc=0, stall_cnt=0.
- Streaming: in_valid=1 with pc 0x0,0x4,0x8,... and inst 0xA0..0xA7 for 8 cycles, out_ready=1 -> each payload appears one cycle after acceptance, in order, with no bubbles and in_ready never 0.
- Backpressure: with pc 0x100 held in main, drop out_ready for 3 cycles while in_valid=1 offering pc 0x104 (then 0x108 queued upstream):
  - In the first stall cycle in_valid+in_ready accepts 0x104 into skid (FULL).
  - in_ready reads 0 from the next cycle on, and 0x108 is not accepted.
  - Re-raise out_ready -> outputs 0x100, 0x104, 0x108 in order.
  - stall_cnt increments by exactly 3.
- Flush: from the FULL state (payloads 0x200 and 0x204 held), pulse flush for 1 cycle while in_valid=1 offering pc 0x300 -> the next cycle shows out_valid=0, out_inst=0x13 and in_ready=1; 0x200, 0x204 and 0x300 never appear on the outputs.
- Stall vs flush: stall=1 and flush=1 in the same cycle while ONE -> the stage goes EMPTY, and stall_cnt does not increment in that cycle.
- Counter saturation with CNT_W=4: hold main_v=1 with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core-wide constants and types for the pipeline stage registers.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } pipe_payload_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; upstream ready is registered.
module pipe_skid_buf
    import core_pkg::*;
#(
    parameter type T = pipe_payload_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    skid_state_e r_state;
    skid_state_e w_state_d;
    logic        r_in_ready;
    T            r_main;
    T            r_skid;
    logic        w_accept;
    logic        w_drain;
    logic        w_main_load;
    logic        w_main_from_skid;
    logic        w_skid_load;

    assign o_valid  = (r_state != StEmpty);
    assign o_ready  = r_in_ready;
    assign o_data   = r_main;
    assign w_accept = i_valid & r_in_ready;
    assign w_drain  = o_valid & i_ready;

    always_comb begin
        w_state_d        = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_state_d   = StOne;
                    w_main_load = 1'b1;
                end
            end
            StOne: begin
                if (w_accept && w_drain) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_state_d   = StFull;
                    w_skid_load = 1'b1;
                end else if (w_drain) begin
                    w_state_d = StEmpty;
                end
            end
            StFull: begin
                if (w_drain) begin
                    w_state_d        = StOne;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_d = StEmpty;
        endcase
        // Flush wins over everything, including a handshake that fired this cycle.
        if (i_flush) begin
            w_state_d        = StEmpty;
            w_main_load      = 1'b0;
            w_main_from_skid = 1'b0;
            w_skid_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d != StFull);
            if (w_main_load) begin
                r_main <= i_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_load) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register carrying {pc, inst} through a skid buffer, with flush, stall,
// NOP masking of idle outputs and a saturating stall-cycle counter.
module pipe_stage_skid
    import core_pkg::*;
#(
    parameter int unsigned       PC_W     = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(core_pkg::NOP_INST),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              flush,
    input  logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } stage_payload_t;

    stage_payload_t   w_in_data;
    stage_payload_t   w_main_data;
    logic             w_main_v;
    logic             w_eff_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in_data.pc   = in_pc;
    assign w_in_data.inst = in_inst;
    assign w_eff_ready    = out_ready & ~stall;

    pipe_skid_buf #(
        .T (stage_payload_t)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_data),
        .o_valid (w_main_v),
        .i_ready (w_eff_ready),
        .o_data  (w_main_data)
    );

    assign out_valid = w_main_v;
    assign out_pc    = w_main_v ? w_main_data.pc : '0;
    assign out_inst  = w_main_v ? w_main_data.inst : NOP_INST;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_v && !w_eff_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector bench for pipe_stage_skid (counter narrowed to 4 bits to reach saturation).
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        flush;
    logic        stall;
    logic [3:0]  stall_cnt;

    int total;
    int bad;

    pipe_stage_skid #(
        .PC_W     (32),
        .INST_W   (32),
        .NOP_INST (32'h0000_0013),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .flush     (flush),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        total++;
        if (out_inst !== 32'h13) begin
            bad++; $display("FAIL reset_out_inst got=%h exp=00000013", out_inst);
        end
        total++;
        if (out_pc !== 32'h0) begin
            bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc);
        end
        total++;
        if (stall_cnt !== 4'd0) begin
            bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_pc   = 32'(i * 4);
            in_inst = 32'hA0 + 32'(i);
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready);
            end
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL stream_out[%0d] got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'(i * 4), 32'hA0 + 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || out_inst !== 32'h13 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL stream_drain got v=%0b pc=%h inst=%h exp v=0 pc=0 inst=13",
                     out_valid, out_pc, out_inst);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_inst   = 32'hB0;
        step();
        // Stall cycles: 0x104 lands in skid on the first, 0x108 is refused afterwards.
        out_ready = 1'b0;
        in_pc     = 32'h104;
        in_inst   = 32'hB1;
        for (int i = 0; i < 3; i++) begin
            step();
            in_pc   = 32'h108;
            in_inst = 32'hB2;
            total++;
            if (in_ready !== 1'b0 || out_pc !== 32'h100 || out_inst !== 32'hB0 ||
                stall_cnt !== 4'(i + 1)) begin
                bad++;
                $display("FAIL bp_hold[%0d] got rdy=%0b pc=%h inst=%h cnt=%0d exp rdy=0 pc=100 inst=b0 cnt=%0d",
                         i, in_ready, out_pc, out_inst, stall_cnt, i + 1);
            end
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_inst !== 32'hB1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second got v=%0b pc=%h inst=%h rdy=%0b exp v=1 pc=104 inst=b1 rdy=1",
                     out_valid, out_pc, out_inst, in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_inst !== 32'hB2) begin
            bad++;
            $display("FAIL bp_third got v=%0b pc=%h inst=%h exp v=1 pc=108 inst=b2",
                     out_valid, out_pc, out_inst);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
            bad++;
            $display("FAIL bp_end got v=%0b cnt=%0d exp v=0 cnt=3", out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h200;
        in_inst  = 32'hC0;
        step();
        in_pc   = 32'h204;
        in_inst = 32'hC1;
        step();
        total++;
        if (in_ready !== 1'b0 || out_pc !== 32'h200) begin
            bad++;
            $display("FAIL flush_full got rdy=%0b pc=%h exp rdy=0 pc=200", in_ready, out_pc);
        end
        flush   = 1'b1;
        in_pc   = 32'h300;
        in_inst = 32'hC2;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_inst !== 32'h13 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty got v=%0b pc=%h inst=%h rdy=%0b exp v=0 pc=0 inst=13 rdy=1",
                     out_valid, out_pc, out_inst, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak[%0d] got v=%0b pc=%h exp v=0", i, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_stall_vs_flush();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h600;
        in_inst   = 32'hD0;
        step();
        in_valid = 1'b0;
        stall    = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h600 || stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL stall_hold got v=%0b pc=%h cnt=%0d exp v=1 pc=600 cnt=1",
                     out_valid, out_pc, stall_cnt);
        end
        // ONE state; accept fires with flush+stall, offered 0x500 must be dropped.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h500;
        in_inst  = 32'hD1;
        step();
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL stall_flush got v=%0b cnt=%0d exp v=0 cnt=1", out_valid, stall_cnt);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL stall_flush_drop got v=%0b pc=%h exp v=0", out_valid, out_pc);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1;
        in_pc    = 32'h700;
        in_inst  = 32'hE0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (stall_cnt !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                bad++;
                $display("FAIL sat[%0d] got=%0d exp=%0d", i, stall_cnt, (i + 1 > 15) ? 15 : i + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h800;
        in_inst   = 32'hF0;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_inst !== 32'h13 || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL async_rst got v=%0b inst=%h cnt=%0d exp v=0 inst=13 cnt=0",
                     out_valid, out_inst, stall_cnt);
        end
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_rst_after got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall_vs_flush();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
